timer_down_n: RTL

Loadable modulo-N down-counter/timer with borrow-out. It is the counting-down counterpart of the lab's up-counting modulo-N counter. It consumes a tick enable and produces a one-cycle borrow pulse on each expiry. Used to time LED step intervals in the flowing-water-light lab, in one-shot or auto-reload mode.

---
 rtl/timer_down_n_pkg.sv | 12 +
 rtl/timer_down_n.sv | 104 ++++++++++
 2 files changed

// File: rtl/timer_down_n_pkg.sv
// Shared lab definitions for the modulo-N down-counter/timer.
package timer_down_n_pkg;

  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/timer_down_n.sv
// Loadable modulo-N down-counter/timer with one-shot or auto-reload runs
// and a single-cycle borrow pulse on every expiry.
module timer_down_n
  import timer_down_n_pkg::*;
#(
  parameter int unsigned N            = 10,
  parameter int unsigned counter_bits = 4
) (
  input  logic                    clk,
  input  logic                    r_n,
  input  logic                    en,
  input  logic                    ld,
  input  logic [counter_bits-1:0] d,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode,
  output logic [counter_bits-1:0] q,
  output logic                    bo,
  output logic                    busy,
  output logic                    done
);

  localparam logic [counter_bits-1:0] RL_MAX = counter_bits'(N - 1);

  state_t                  state, state_nxt;
  logic [counter_bits-1:0] q_nxt;
  logic [counter_bits-1:0] rl;
  logic [counter_bits-1:0] d_clamped;
  logic [counter_bits-1:0] start_val;

  // A start in the same cycle as a load picks up the freshly clamped value.
  assign d_clamped = (32'(d) >= N) ? RL_MAX : d;
  assign start_val = ld ? d_clamped : rl;

  // State, count and reload registers.
  always_ff @(posedge clk) begin
    if (!r_n) begin
      state <= S_IDLE;
      q     <= '0;
      rl    <= RL_MAX;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      if (ld) rl <= d_clamped;
    end
  end

  // Next state and next count: stop > start > enabled count.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    case (state)
      S_IDLE: begin
        if (!stop && start) begin
          state_nxt = S_RUN;
          q_nxt     = start_val;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (start) begin
          q_nxt = start_val;
        end else if (en) begin
          if (q != '0) begin
            q_nxt = q - counter_bits'(1);
          end else if (mode) begin
            q_nxt = rl;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (start) begin
          state_nxt = S_RUN;
          q_nxt     = start_val;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        q_nxt     = '0;
      end
    endcase
  end

  // Status decode; bo follows en combinationally within a RUN cycle at zero.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    bo   = 1'b0;
    case (state)
      S_RUN: begin
        busy = 1'b1;
        bo   = (q == '0) && en;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
